// File: rtl/result_writeback_router_pkg.sv
// result_writeback_router_pkg: shared destination encodings, default widths and channel-entry layout for the writeback router.
package result_writeback_router_pkg;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_NUM_REGISTERS = 8;
  localparam int DEF_NUM_PREDICATES = 8;
  localparam int DEF_NUM_OUT_CHANNELS = 4;
  localparam int DEF_TAG_WIDTH = 2;
  localparam int DEF_CHANNEL_DEPTH = 4;
  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_REG = 2'd1,
    DEST_CHANNEL = 2'd2,
    DEST_PRED = 2'd3
  } dest_type_t;
  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0] tag;
    logic [DEF_WORD_WIDTH-1:0] data;
  } ch_entry_t;
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/result_writeback_router_channel_fifo.sv
// channel_fifo: per-channel output queue; ports clk, rst (sync, active-high), push/push_data, ready -> valid/data head, count; macro TIA_CHANNEL_FALLTHROUGH_EN lets a push into an empty queue appear at the head in the same cycle.
module channel_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic empty, pop, wr, rd;
  assign empty = count == '0;
`ifdef TIA_CHANNEL_FALLTHROUGH_EN
  assign valid = !empty || push;
  assign data = empty ? push_data : mem[rd_ptr];
`else
  assign valid = !empty;
  assign data = mem[rd_ptr];
`endif
  assign pop = valid && ready;
  assign rd = pop && !empty;
  // a pop while empty can only be the bypassed push, which never takes a slot
  assign wr = push && !(empty && pop);
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/result_writeback_router.sv
// result_writeback_router: commits ALU results to the register-file port, predicate port or tagged channel FIFOs; ports clock, reset, in_* issue handshake, rf_*/pred_* registered writes, ch_* per-channel heads, halted; macro TIA_CHANNEL_FALLTHROUGH_EN enables same-cycle channel fallthrough.
module result_writeback_router
  import result_writeback_router_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
  parameter int NUM_PREDICATES = DEF_NUM_PREDICATES,
  parameter int NUM_OUT_CHANNELS = DEF_NUM_OUT_CHANNELS,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int CHANNEL_DEPTH = DEF_CHANNEL_DEPTH,
  localparam int IW = $clog2(max3(NUM_REGISTERS, NUM_PREDICATES, NUM_OUT_CHANNELS)),
  localparam int RW = $clog2(NUM_REGISTERS),
  localparam int PW = $clog2(NUM_PREDICATES)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [1:0]                             in_dest_type,
  input  logic [IW-1:0]                          in_dest_index,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  input  logic [WORD_WIDTH-1:0]                  in_result,
  input  logic                                   in_halt,
  output logic                                   rf_wen,
  output logic [RW-1:0]                          rf_windex,
  output logic [WORD_WIDTH-1:0]                  rf_wdata,
  output logic                                   pred_wen,
  output logic [PW-1:0]                          pred_windex,
  output logic                                   pred_wvalue,
  output logic [NUM_OUT_CHANNELS-1:0]            ch_valid,
  input  logic [NUM_OUT_CHANNELS-1:0]            ch_ready,
  output logic [NUM_OUT_CHANNELS*WORD_WIDTH-1:0] ch_data,
  output logic [NUM_OUT_CHANNELS*TAG_WIDTH-1:0]  ch_tag,
  output logic                                   halted
);
  localparam int CW = $clog2(NUM_OUT_CHANNELS);
  localparam int AW = $clog2(CHANNEL_DEPTH);
  localparam int EW = TAG_WIDTH + WORD_WIDTH;
  dest_type_t dest;
  logic [AW:0] count [NUM_OUT_CHANNELS];
  logic reg_ok, pred_ok, ch_ok, ch_full, accept, live;
  assign dest = dest_type_t'(in_dest_type);
  assign reg_ok = {1'b0, in_dest_index} < (IW+1)'(NUM_REGISTERS);
  assign pred_ok = {1'b0, in_dest_index} < (IW+1)'(NUM_PREDICATES);
  assign ch_ok = {1'b0, in_dest_index} < (IW+1)'(NUM_OUT_CHANNELS);
  // stall only on current occupancy so ch_ready never reaches in_ready
  assign ch_full = ch_ok && count[in_dest_index[CW-1:0]] == (AW+1)'(CHANNEL_DEPTH);
  assign in_ready = !halted && !(dest == DEST_CHANNEL && ch_full);
  assign accept = in_valid && in_ready;
  assign live = accept && !in_halt;
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wen <= 1'b0;
      rf_windex <= '0;
      rf_wdata <= '0;
      pred_wen <= 1'b0;
      pred_windex <= '0;
      pred_wvalue <= 1'b0;
      halted <= 1'b0;
    end else begin
      rf_wen <= live && dest == DEST_REG && reg_ok;
      pred_wen <= live && dest == DEST_PRED && pred_ok;
      halted <= halted || (accept && in_halt);
      if (live && dest == DEST_REG && reg_ok) begin
        rf_windex <= in_dest_index[RW-1:0];
        rf_wdata <= in_result;
      end
      if (live && dest == DEST_PRED && pred_ok) begin
        pred_windex <= in_dest_index[PW-1:0];
        pred_wvalue <= |in_result;
      end
    end
  end
  for (genvar c = 0; c < NUM_OUT_CHANNELS; c++) begin : g_ch
    logic [EW-1:0] head;
    channel_fifo #(.WIDTH(EW), .DEPTH(CHANNEL_DEPTH)) u_fifo (
      .clk(clock),
      .rst(reset),
      .push(live && dest == DEST_CHANNEL && ch_ok && in_dest_index[CW-1:0] == CW'(c)),
      .push_data({in_tag, in_result}),
      .ready(ch_ready[c]),
      .valid(ch_valid[c]),
      .data(head),
      .count(count[c])
    );
    assign ch_tag[c*TAG_WIDTH +: TAG_WIDTH] = head[EW-1:WORD_WIDTH];
    assign ch_data[c*WORD_WIDTH +: WORD_WIDTH] = head[WORD_WIDTH-1:0];
  end
endmodule
